spi_master_ctrl: RTL

//  Sequences single-character SPI transfers from a request port onto the serial bus; owns SCLK/MOSI/CS_n.

---
 rtl/globals_pkg.sv | 5 +
 rtl/spi_ctrl_pkg.sv | 14 +
 rtl/spi_sclk_gen.sv | 66 ++++++
 rtl/spi_master_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/globals_pkg.sv
// Project-wide sizing shared by the SPI controller and the slave models.
package globals_pkg;
    // Five slaves gives a 3-bit index, so indices 5..7 exercise the out-of-range path.
    localparam int NO_OF_SLAVES = 5;
endpackage

// File: rtl/spi_ctrl_pkg.sv
// Types and widths for the SPI master controller: FSM state encoding and slave index width.
package spi_ctrl_pkg;
    import globals_pkg::NO_OF_SLAVES;

    localparam int SLV_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        XFER,
        CS_HOLD,
        DONE
    } spi_ctrl_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: BAUD_DIV half-period divider plus edge counter, emitting edge strobes
// that coincide with the pclk edge on which sclk toggles.
module spi_sclk_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 2
) (
    input  logic pclk,
    input  logic areset,
    input  logic en_i,
    input  logic set_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic lead_edge_o,
    output logic trail_edge_o,
    output logic last_edge_o,
    output logic done_o
);
    localparam int DW = $clog2(BAUD_DIV + 1);
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BAUD_DIV);
    localparam logic [EW-1:0] EDGE_MAX = EW'(2 * DATA_WIDTH);

    logic [DW-1:0] div_q, div_d;
    logic [EW-1:0] edge_q, edge_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    // Counters are held at their load values outside XFER, so entering XFER reloads them.
    always_comb begin
        tick   = en_i && (div_q == DIV_MAX) && (edge_q != EDGE_MAX);
        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = DW'(1);
            edge_d = '0;
        end else if (tick) begin
            div_d  = DW'(1);
            edge_d = edge_q + EW'(1);
            sclk_d = ~sclk_q;
        end else if (edge_q != EDGE_MAX) begin
            div_d  = div_q + DW'(1);
        end
        if (set_i) begin
            sclk_d = cpol_i;
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            div_q  <= DW'(1);
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o       = sclk_q;
    assign lead_edge_o  = tick && !edge_q[0];
    assign trail_edge_o = tick && edge_q[0];
    assign last_edge_o  = tick && (edge_q == EDGE_MAX - EW'(1));
    assign done_o       = en_i && (edge_q == EDGE_MAX);
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts one-character requests, drives SCLK/MOSI/CS_n and returns MISO data.
// Optional CS setup/hold delay states are enabled by defining SPI_CS_DELAY_EN.
module spi_master_ctrl
    import globals_pkg::*;
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 2,
    parameter int CS_DLY     = 2
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [SLV_W-1:0]        req_slave,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic                    req_cpol,
    input  logic                    req_cpha,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [NO_OF_SLAVES-1:0] cs_n
);
    localparam int DW = DATA_WIDTH;

    if (DATA_WIDTH < 2 || DATA_WIDTH > 32 || BAUD_DIV < 1 || CS_DLY < 1) begin : g_bad_params
        $error("spi_master_ctrl: illegal parameter value");
    end

    spi_ctrl_state_e         state_q;
    logic                    ready_q, busy_q, rsp_valid_q, rsp_err_q, mosi_q, cpha_q;
    logic [DW-1:0]           rsp_data_q, tx_q, rx_q;
    logic [NO_OF_SLAVES-1:0] cs_n_q, cs_dec;
`ifdef SPI_CS_DELAY_EN
    localparam int CW = $clog2(CS_DLY + 1);
    logic [CW-1:0]           dly_q;
`endif

    logic accept, slave_oob, shift_edge, sample_edge;
    logic lead_edge, trail_edge, last_edge, xfer_done;

    always_comb begin
        accept    = ready_q && req_valid;
        slave_oob = int'(req_slave) >= NO_OF_SLAVES;
        cs_dec    = '1;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (int'(req_slave) == i) cs_dec[i] = 1'b0;
        end
        // cpha=0 presents the MSB at CS assert, so its final trailing edge has nothing left to shift.
        shift_edge  = cpha_q ? lead_edge : (trail_edge && !last_edge);
        sample_edge = cpha_q ? trail_edge : lead_edge;
    end

    spi_sclk_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .BAUD_DIV   (BAUD_DIV)
    ) u_sclk_gen (
        .pclk         (pclk),
        .areset       (areset),
        .en_i         (state_q == XFER),
        .set_i        (accept && !slave_oob),
        .cpol_i       (req_cpol),
        .sclk_o       (sclk),
        .lead_edge_o  (lead_edge),
        .trail_edge_o (trail_edge),
        .last_edge_o  (last_edge),
        .done_o       (xfer_done)
    );

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            cs_n_q      <= '1;
            mosi_q      <= 1'b0;
            cpha_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
`ifdef SPI_CS_DELAY_EN
            dly_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            if (shift_edge) begin
                mosi_q <= tx_q[DW-1];
                tx_q   <= {tx_q[DW-2:0], 1'b0};
            end
            if (sample_edge) begin
                rx_q <= {rx_q[DW-2:0], miso};
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (slave_oob) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            cs_n_q <= cs_dec;
                            cpha_q <= req_cpha;
                            tx_q   <= req_cpha ? req_data : {req_data[DW-2:0], 1'b0};
                            mosi_q <= req_cpha ? 1'b0 : req_data[DW-1];
                            rx_q   <= '0;
`ifdef SPI_CS_DELAY_EN
                            state_q <= CS_SETUP;
                            dly_q   <= CW'(1);
`else
                            state_q <= XFER;
`endif
                        end
                    end
                end
                CS_SETUP: begin
`ifdef SPI_CS_DELAY_EN
                    if (dly_q == CW'(CS_DLY)) state_q <= XFER;
                    else dly_q <= dly_q + CW'(1);
`else
                    state_q <= XFER;
`endif
                end
                XFER: begin
                    if (xfer_done) begin
`ifdef SPI_CS_DELAY_EN
                        state_q <= CS_HOLD;
                        dly_q   <= CW'(1);
`else
                        state_q     <= DONE;
                        cs_n_q      <= '1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= rx_q;
`endif
                    end
                end
                CS_HOLD: begin
`ifdef SPI_CS_DELAY_EN
                    if (dly_q == CW'(CS_DLY)) begin
                        state_q     <= DONE;
                        cs_n_q      <= '1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= rx_q;
                    end else begin
                        dly_q <= dly_q + CW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
endmodule
